// File: rtl/axis_move_sequencer.sv
// Command front-end for one stepper axis: absolute moves, homing, position tracking, coil mux.
// Optional MOVE_LIMIT_EN: reject move targets above MAX_POS.
module axis_move_sequencer #(
    parameter int POS_W      = 12,
    parameter int MAX_POS    = 2000,
    parameter int HOME_STEPS = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_home,
    input  logic [POS_W-1:0] cmd_target,
    output logic [POS_W-1:0] move_steps,
    output logic             fwd_go,
    output logic             bwd_go,
    input  logic             fwd_done,
    input  logic             bwd_done,
    input  logic [3:0]       fwd_state,
    input  logic [3:0]       bwd_state,
    input  logic             boundary,
    output logic [3:0]       hold_state,
    output logic [3:0]       coil_state,
    output logic [POS_W-1:0] position,
    output logic             homed,
    output logic             busy,
    output logic             move_done,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, RUN_FWD, RUN_BWD, HOME, RELEASE} state_t;

    localparam logic [POS_W-1:0] MAX_POS_W    = MAX_POS[POS_W-1:0];
    localparam logic [POS_W-1:0] HOME_STEPS_W = HOME_STEPS[POS_W-1:0];
`ifdef MOVE_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_t           state;
    logic [POS_W-1:0] target_reg;
    logic             limit_hit;

    assign limit_hit = LIMIT_EN && (cmd_target > MAX_POS_W);

    // The running generator owns the coils; otherwise keep the last pattern energised.
    always_comb begin
        coil_state = hold_state;
        case (state)
            RUN_FWD:       coil_state = fwd_state;
            RUN_BWD, HOME: coil_state = bwd_state;
            default:       coil_state = hold_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            fwd_go     <= 1'b0;
            bwd_go     <= 1'b0;
            move_steps <= '0;
            hold_state <= 4'b1100;
            position   <= '0;
            target_reg <= '0;
            homed      <= 1'b0;
            busy       <= 1'b0;
            move_done  <= 1'b0;
            err        <= 1'b0;
        end else begin
            move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_home) begin
                            err        <= 1'b0;
                            move_steps <= HOME_STEPS_W;
                            bwd_go     <= 1'b1;
                            cmd_ready  <= 1'b0;
                            busy       <= 1'b1;
                            state      <= HOME;
                        end else if (!homed || limit_hit) begin
                            err       <= 1'b1;
                            move_done <= 1'b1;
                        end else begin
                            err        <= 1'b0;
                            target_reg <= cmd_target;
                            if (cmd_target > position) begin
                                move_steps <= cmd_target - position;
                                fwd_go     <= 1'b1;
                                cmd_ready  <= 1'b0;
                                busy       <= 1'b1;
                                state      <= RUN_FWD;
                            end else if (cmd_target < position) begin
                                move_steps <= position - cmd_target;
                                bwd_go     <= 1'b1;
                                cmd_ready  <= 1'b0;
                                busy       <= 1'b1;
                                state      <= RUN_BWD;
                            end else begin
                                move_done <= 1'b1;
                            end
                        end
                    end
                end
                RUN_FWD: begin
                    if (fwd_done) begin
                        fwd_go     <= 1'b0;
                        hold_state <= fwd_state;
                        state      <= RELEASE;
                        // Hitting the end-stop mid-move means the position can no longer be trusted.
                        if (boundary) begin
                            homed <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            position <= target_reg;
                        end
                    end
                end
                RUN_BWD: begin
                    if (bwd_done) begin
                        bwd_go     <= 1'b0;
                        hold_state <= bwd_state;
                        state      <= RELEASE;
                        if (boundary) begin
                            homed <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            position <= target_reg;
                        end
                    end
                end
                HOME: begin
                    if (bwd_done) begin
                        bwd_go     <= 1'b0;
                        hold_state <= bwd_state;
                        state      <= RELEASE;
                        if (boundary) begin
                            position <= '0;
                            homed    <= 1'b1;
                        end else begin
                            err   <= 1'b1;
                            homed <= 1'b0;
                        end
                    end
                end
                RELEASE: begin
                    move_done <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    fwd_go    <= 1'b0;
                    bwd_go    <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
